shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//   Command-driven controller for the 8-bit shift/rotate unit (SLL/SRL/SLA/SRA/ROL/ROR/hold).
//   Accepts one command (op, amount, data) via valid/ready and applies a 1-bit step per cycle, amount times.
//   Returns the result via valid/ready; sits between a requester and the shift datapath.
// PARAMETERS
//   WIDTH  8  data width in bits
//   AMT_W  3  shift-amount width; equals clog2(WIDTH), giving amounts 0..WIDTH-1
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-low reset
//   cmd_valid  in   1      command offered
//   cmd_ready  out  1      command accepted when cmd_valid && cmd_ready at a rising edge
//   cmd_op     in   3      0 HOLD, 1 SLL, 2 SRL, 3 SLA, 4 SRA, 5 ROL, 6 ROR, 7 reserved (=HOLD)
//   cmd_amt    in   AMT_W  number of 1-bit steps
//   cmd_data   in   WIDTH  operand
//   res_valid  out  1      result available
//   res_ready  in   1      result consumed when res_valid && res_ready at a rising edge
//   res_data   out  WIDTH  result; stable while res_valid
//   busy       out  1      high in SHIFT or DONE
// BEHAVIOUR
//   Reset: rst==0 at a rising edge -> state IDLE, shreg=0, cnt=0, op_r=0.
//     res_valid=0, busy=0, res_data=0; cmd_ready is forced 0 while rst==0.
//   FSM states: IDLE, SHIFT, DONE.
//   - IDLE: cmd_ready=1. On accept: shreg<=cmd_data, op_r<=cmd_op, cnt<=cmd_amt.
//     Next state is DONE if cmd_amt==0, otherwise SHIFT.
//   - SHIFT: each edge, shreg<=step(op_r, shreg) and cnt<=cnt-1. When cnt==1, next state is DONE.
//   - DONE: res_valid=1, res_data=shreg. On res_ready, next state is IDLE.
//     Otherwise hold, with res_data frozen.
//   Step functions, with q = shreg:
//     SLL {q[W-2:0],0}; SRL {0,q[W-1:1]}; SLA {q[W-1],q[W-3:0],0} (sign bit kept);
//     SRA {q[W-1],q[W-1:1]}; ROL {q[W-2:0],q[W-1]}; ROR {q[0],q[W-1:1]};
//     HOLD and reserved leave q unchanged (still consume amt cycles).
//   Latency: with accept at edge E0, res_valid is first high in the cycle after edge E0+amt.
//     amt=0 gives 1 cycle; 1 command per amt+2 cycles with no back-pressure.
//   cmd_ready=0 in SHIFT/DONE; cmd_valid there is ignored and inputs are not sampled.
//     The requester holds its command until accepted.
//   res_ready while not in DONE has no effect.
//   No modulo arithmetic on amt: the full range 0..WIDTH-1 is legal.
//     ROL/ROR by amt equals a rotate by amt mod WIDTH.
//   Reset mid-operation (SHIFT or DONE): command aborted, no result issued, IDLE next cycle.
//   res_data reads shreg only in DONE; it drives 0 in other states.
// STRUCTURE
//   shift_pkg: op-code localparams (OP_HOLD..OP_ROR), FSM state encoding (2 bits), default WIDTH.
//   Sub-module shift_step (combinational): ports op, din -> dout. It implements one 1-bit step.
//   shift_sequencer holds the FSM, shreg, cnt, op_r and handshake logic.
// TESTING  (all with cmd_data=8'b1001_0101)
//   SLL, amt 3, res_ready=1 -> res_data=8'hA8; res_valid in the cycle after edge E0+3; then IDLE.
//   SRA, amt 2 -> 8'hE5; SLA, amt 2 -> 8'hD4 (MSB kept); ROR, amt 1 -> 8'hCA.
//   ROL, amt 0 -> 8'h95 in the cycle after accept; SHIFT never entered; busy high 1 cycle.
//   Back-pressure: res_ready=0 for 5 cycles in DONE -> res_data stable, cmd_ready=0.
//     A pending cmd_valid is not accepted until the cycle after the result handshake.
//   Reset mid-op: SRL amt 7, rst=0 at the 3rd SHIFT edge -> IDLE, res_valid never asserts.
//     A following ROR amt 1 -> 8'hCA.
//   Reserved op 7, amt 4 -> res_data=8'h95 after 4 SHIFT cycles.
//   Back-to-back SLL amt 1 commands with a constant-high handshake -> accepts spaced exactly 3 cycles.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants for the shift sequencer: op-codes, FSM encoding, default width.
package shift_pkg;

    localparam int WIDTH_DEF = 8;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_SLL  = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_SLA  = 3'd3;
    localparam logic [2:0] OP_SRA  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// One 1-bit shift/rotate step; HOLD and the reserved code pass data through.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        case (op)
            OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
            OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
            // Arithmetic left keeps the sign bit and drops bit WIDTH-2.
            OP_SLA:  dout = {din[WIDTH-1], din[WIDTH-3:0], 1'b0};
            OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
            OP_ROL:  dout = {din[WIDTH-2:0], din[WIDTH-1]};
            OP_ROR:  dout = {din[0], din[WIDTH-1:1]};
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer applying one shift step per cycle, amt times.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   SHIFT | stepping shreg once per cycle until cnt reaches 1
//   DONE  | result presented, waiting for res_ready
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       op_r;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op   (op_r),
        .din  (shreg),
        .dout (shreg_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
            op_r  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        shreg <= cmd_data;
                        op_r  <= cmd_op;
                        cnt   <= cmd_amt;
                        state <= (cmd_amt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shreg <= shreg_nxt;
                    cnt   <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ready is gated by rst so nothing is accepted while reset is held.
    assign cmd_ready = rst && (state == ST_IDLE);
    assign res_valid = (state == ST_DONE);
    assign res_data  = res_valid ? shreg : '0;
    assign busy      = (state == ST_SHIFT) || (state == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: the driver queues expected results on accept, the monitor checks them.
module tb_shift_sequencer;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [2:0] cmd_amt = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic       busy;

    shift_sequencer #(.WIDTH(8), .AMT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         first;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: latency on the first valid cycle, data on every valid cycle, pop on handshake.
    bit in_res = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            in_res = 1'b0;
        end else if (res_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(res_valid), 32'd0);
            end else begin
                if (!in_res) check("latency", 32'(cyc), 32'(exp_q[0].first));
                check("res_data", 32'(res_data), 32'(exp_q[0].data));
                in_res = 1'b1;
                if (res_ready) begin
                    void'(exp_q.pop_front());
                    in_res = 1'b0;
                end
            end
        end
    end

    task automatic wait_accept(input logic [7:0] exp, input int amt, output int acc);
        bit got = 1'b0;
        acc = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready && cmd_valid) begin
                got = 1'b1;
                acc = cyc + 1;
                exp_q.push_back('{data: exp, first: acc + amt});
            end
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] amt, input logic [7:0] data,
                        input logic [7:0] exp, output int acc);
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = data;
        cmd_valid = 1'b1;
        wait_accept(exp, int'(amt), acc);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        int acc2;
        int hs;
        int accs[3];
        bit seen;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        send(OP_SLL, 3'd3, 8'h95, 8'hA8, acc);
        wait_idle();
        check("sll_then_idle", 32'(cmd_ready), 32'd1);

        send(OP_SRA, 3'd2, 8'h95, 8'hE5, acc);
        wait_idle();
        send(OP_SLA, 3'd2, 8'h95, 8'hD4, acc);
        wait_idle();
        send(OP_ROR, 3'd1, 8'h95, 8'hCA, acc);
        wait_idle();

        // amt 0 goes straight to DONE: busy for exactly one cycle.
        send(OP_ROL, 3'd0, 8'h95, 8'h95, acc);
        @(negedge clk);
        check("rol0_busy_on", 32'(busy), 32'd1);
        @(negedge clk);
        check("rol0_busy_off", 32'(busy), 32'd0);
        wait_idle();

        send(3'd7, 3'd4, 8'h95, 8'h95, acc);
        wait_idle();

        // Back-pressure with a second command already pending.
        res_ready = 1'b0;
        send(OP_SRL, 3'd1, 8'h95, 8'h4A, acc);
        cmd_op    = OP_ROR;
        cmd_amt   = 3'd1;
        cmd_data  = 8'h95;
        cmd_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("bp_res_valid_seen", 32'(seen), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_res_valid", 32'(res_valid), 32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        hs = cyc + 1;
        wait_accept(8'hCA, 1, acc2);
        cmd_valid = 1'b0;
        check("bp_accept_after_hs", 32'(acc2), 32'(hs + 1));
        wait_idle();

        // Reset lands on the third SHIFT edge.
        send(OP_SRL, 3'd7, 8'h95, 8'h01, acc);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 exp_q.delete();
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_cmd_ready_after", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_result", 32'(res_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(OP_ROR, 3'd1, 8'h95, 8'hCA, acc);
        wait_idle();

        // Back-to-back with constant-high handshake.
        cmd_op    = OP_SLL;
        cmd_amt   = 3'd1;
        cmd_data  = 8'h95;
        cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_accept(8'h2A, 1, accs[k]);
        end
        cmd_valid = 1'b0;
        check("b2b_spacing_1", 32'(accs[1] - accs[0]), 32'd3);
        check("b2b_spacing_2", 32'(accs[2] - accs[1]), 32'd3);
        wait_idle();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
